ex_branch_stage: RTL and testbench

- Execute stage wrapped around the combinational ALU.
- Accepts decoded instructions from ID over a valid/ready handshake and drives the ALU operand and control pins.
- Resolves branches and jumps from the ALU eq/lt/ltu flags.
- Registers results into the EX/MEM pipeline register. Issues a one-cycle redirect to IF on a taken control transfer, and uses a 1-bit epoch to discard wrong-path instructions still in flight.

---
 rtl/ex_branch_stage_if.sv | 62 ++++++
 rtl/ex_branch_stage.sv | 90 +++++++++
 tb/tb_ex_branch_stage.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/ex_branch_stage_if.sv
// ID->EX instruction bus, EX<->ALU pins, EX/MEM register outputs and IF redirect.
// Pure wiring bundle; no latency of its own.
// Handshakes are valid/ready on the ID and MEM sides; redirect is a one-cycle pulse.
interface ex_branch_stage_if #(
  parameter int DATA_WIDTH = 32,
  parameter int RA_W       = 5
);
  // ID -> EX
  logic                  in_valid;
  logic                  in_ready;
  logic                  in_epoch;
  logic [DATA_WIDTH-1:0] in_pc;
  logic [DATA_WIDTH-1:0] in_rs1;
  logic [DATA_WIDTH-1:0] in_rs2;
  logic [DATA_WIDTH-1:0] in_imm;
  logic                  in_a_sel;
  logic                  in_b_sel;
  logic [3:0]            in_ctl;
  logic [2:0]            in_br;
  logic                  in_jalr;
  logic [RA_W-1:0]       in_rd;
  logic                  in_wen;
  // EX <-> ALU
  logic [DATA_WIDTH-1:0] alu_a;
  logic [DATA_WIDTH-1:0] alu_b;
  logic [3:0]            alu_ctl;
  logic [DATA_WIDTH-1:0] alu_res;
  logic                  alu_eq;
  logic                  alu_lt;
  logic                  alu_ltu;
  // EX/MEM register
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_res;
  logic [RA_W-1:0]       out_rd;
  logic                  out_wen;
  logic                  out_misalign;
  // redirect to IF, kill from later stage
  logic                  redirect_valid;
  logic [DATA_WIDTH-1:0] redirect_pc;
  logic                  flush;

  // Environment side: ID, ALU, MEM and the flush source.
  modport master (
    output in_valid, in_epoch, in_pc, in_rs1, in_rs2, in_imm, in_a_sel, in_b_sel,
           in_ctl, in_br, in_jalr, in_rd, in_wen,
           alu_res, alu_eq, alu_lt, alu_ltu, out_ready, flush,
    input  in_ready, alu_a, alu_b, alu_ctl,
           out_valid, out_res, out_rd, out_wen, out_misalign,
           redirect_valid, redirect_pc
  );

  // Execute-stage side.
  modport slave (
    input  in_valid, in_epoch, in_pc, in_rs1, in_rs2, in_imm, in_a_sel, in_b_sel,
           in_ctl, in_br, in_jalr, in_rd, in_wen,
           alu_res, alu_eq, alu_lt, alu_ltu, out_ready, flush,
    output in_ready, alu_a, alu_b, alu_ctl,
           out_valid, out_res, out_rd, out_wen, out_misalign,
           redirect_valid, redirect_pc
  );
endinterface

// File: rtl/ex_branch_stage.sv
// Execute stage: drives the ALU, resolves branches/jumps, loads the EX/MEM register.
// Latency 1 cycle from accepted instruction to out_valid / redirect pulse.
// Stalls ID (in_ready=0) while the output is held; stale-epoch instructions are always consumed.
module ex_branch_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int RA_W       = 5
) (
  input logic             clk,
  input logic             rst_n,
  ex_branch_stage_if.slave bus
);

  localparam logic [DATA_WIDTH-1:0] FOUR    = DATA_WIDTH'(4);
  localparam logic [DATA_WIDTH-1:0] LSB_CLR = ~DATA_WIDTH'(1);

  logic                  epoch;
  logic                  stale;
  logic                  fire;
  logic                  taken;
  logic                  is_jump;
  logic                  is_branch;
  logic [DATA_WIDTH-1:0] target;
  logic [DATA_WIDTH-1:0] link;

  // Operand muxing straight from the decoded instruction.
  assign bus.alu_a   = bus.in_a_sel ? bus.in_pc  : bus.in_rs1;
  assign bus.alu_b   = bus.in_b_sel ? bus.in_imm : bus.in_rs2;
  assign bus.alu_ctl = bus.in_ctl;

  // Wrong-path instructions carry the old epoch; they are swallowed even under back-pressure.
  assign stale        = bus.in_epoch != epoch;
  assign bus.in_ready = stale | ~bus.out_valid | bus.out_ready;
  assign fire         = bus.in_valid & bus.in_ready & ~stale & ~bus.flush;

  assign is_jump   = bus.in_br == 3'd7;
  assign is_branch = (bus.in_br != 3'd0) & ~is_jump;

  // jalr target comes from the ALU (rs1+imm); everything else uses the local pc+imm adder.
  assign target = (is_jump & bus.in_jalr) ? (bus.alu_res & LSB_CLR) : (bus.in_pc + bus.in_imm);
  assign link   = bus.in_pc + FOUR;

  // Branch condition from the ALU compare flags.
  always_comb begin
    taken = 1'b0;
    case (bus.in_br)
      3'd1:    taken = bus.alu_eq;
      3'd2:    taken = ~bus.alu_eq;
      3'd3:    taken = bus.alu_lt;
      3'd4:    taken = ~bus.alu_lt;
      3'd5:    taken = bus.alu_ltu;
      3'd6:    taken = ~bus.alu_ltu;
      3'd7:    taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

  // EX/MEM register, redirect pulse and epoch; flush overrides everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid      <= 1'b0;
      bus.out_res        <= '0;
      bus.out_rd         <= '0;
      bus.out_wen        <= 1'b0;
      bus.out_misalign   <= 1'b0;
      bus.redirect_valid <= 1'b0;
      bus.redirect_pc    <= '0;
      epoch              <= 1'b0;
    end else if (bus.flush) begin
      bus.out_valid      <= 1'b0;
      bus.redirect_valid <= 1'b0;
    end else begin
      bus.redirect_valid <= 1'b0;
      if (fire) begin
        bus.out_valid    <= 1'b1;
        bus.out_rd       <= bus.in_rd;
        bus.out_wen      <= bus.in_wen & ~is_branch;
        bus.out_res      <= is_jump ? link : bus.alu_res;
        bus.out_misalign <= taken & target[1];
        if (taken) begin
          bus.redirect_valid <= 1'b1;
          bus.redirect_pc    <= target;
          epoch              <= ~epoch;
        end
      end else if (bus.out_valid & bus.out_ready) begin
        bus.out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ex_branch_stage.sv
// Directed + random bench for ex_branch_stage against a transaction-level model.
// Inputs change on the falling edge; outputs are checked 1 time unit after each rising edge.
// The ALU is emulated by the bench from the instruction operands.
module tb_ex_branch_stage;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  ex_branch_stage_if #(.DATA_WIDTH(32), .RA_W(5)) bus ();

  ex_branch_stage #(.DATA_WIDTH(32), .RA_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Model state: what the EX/MEM register and redirect should hold.
  logic        m_ov, m_wen, m_mis, m_rv, m_ep;
  logic [31:0] m_res, m_rpc;
  logic [4:0]  m_rd;
  logic [31:0] alu_v;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ov = 0; m_wen = 0; m_mis = 0; m_rv = 0; m_ep = 0;
    m_res = 0; m_rpc = 0; m_rd = 0;
  endtask

  // Present an instruction and the matching ALU response.
  task automatic put(input logic v, input logic ep, input logic [31:0] pc, input logic [31:0] rs1,
                     input logic [31:0] rs2, input logic [31:0] imm, input logic as, input logic bs,
                     input logic [3:0] ctl, input logic [2:0] br, input logic jr,
                     input logic [4:0] rd, input logic wen);
    logic [31:0] a, b;
    bus.in_valid = v;  bus.in_epoch = ep; bus.in_pc = pc;   bus.in_rs1 = rs1;
    bus.in_rs2 = rs2;  bus.in_imm = imm;  bus.in_a_sel = as; bus.in_b_sel = bs;
    bus.in_ctl = ctl;  bus.in_br = br;    bus.in_jalr = jr;  bus.in_rd = rd; bus.in_wen = wen;
    a = as ? pc : rs1;
    b = bs ? imm : rs2;
    case (ctl)
      4'b0000: alu_v = a + b;
      4'b1000: alu_v = a - b;
      default: alu_v = a ^ b;
    endcase
    bus.alu_res = alu_v;
    bus.alu_eq  = (a == b);
    bus.alu_lt  = ($signed(a) < $signed(b));
    bus.alu_ltu = (a < b);
  endtask

  task automatic check_outs(input string tag);
    chk({tag, ".out_valid"}, bus.out_valid, m_ov);
    chk({tag, ".out_res"}, bus.out_res, m_res);
    chk({tag, ".out_rd"}, bus.out_rd, m_rd);
    chk({tag, ".out_wen"}, bus.out_wen, m_wen);
    chk({tag, ".out_misalign"}, bus.out_misalign, m_mis);
    chk({tag, ".redirect_valid"}, bus.redirect_valid, m_rv);
    chk({tag, ".redirect_pc"}, bus.redirect_pc, m_rpc);
  endtask

  // One clock: starts and ends at a falling edge with inputs already applied.
  task automatic cycle(input string tag);
    logic        stale, rdy, vf, tk;
    logic [31:0] pc, rs1, rs2, imm, tgt;
    pc = bus.in_pc; rs1 = bus.in_rs1; rs2 = bus.in_rs2; imm = bus.in_imm;
    #1;
    stale = (bus.in_epoch != m_ep);
    rdy   = stale || !m_ov || bus.out_ready;
    chk({tag, ".in_ready"}, bus.in_ready, rdy);
    chk({tag, ".alu_a"}, bus.alu_a, bus.in_a_sel ? pc : rs1);
    chk({tag, ".alu_b"}, bus.alu_b, bus.in_b_sel ? imm : rs2);
    chk({tag, ".alu_ctl"}, bus.alu_ctl, bus.in_ctl);
    case (bus.in_br)
      3'd1: tk = (rs1 == rs2);
      3'd2: tk = (rs1 != rs2);
      3'd3: tk = ($signed(rs1) < $signed(rs2));
      3'd4: tk = ($signed(rs1) >= $signed(rs2));
      3'd5: tk = (rs1 < rs2);
      3'd6: tk = (rs1 >= rs2);
      3'd7: tk = 1'b1;
      default: tk = 1'b0;
    endcase
    tgt = (bus.in_br == 3'd7 && bus.in_jalr) ? {alu_v[31:1], 1'b0} : pc + imm;
    vf  = bus.in_valid && rdy && !stale && !bus.flush;
    if (bus.flush) begin
      m_ov = 0; m_rv = 0;
    end else begin
      m_rv = 0;
      if (vf) begin
        m_ov  = 1;
        m_rd  = bus.in_rd;
        m_wen = bus.in_wen && (bus.in_br == 0 || bus.in_br == 7);
        m_res = (bus.in_br == 7) ? pc + 32'd4 : alu_v;
        m_mis = tk && (tgt % 4 >= 2);
        if (tk) begin
          m_rv = 1; m_rpc = tgt; m_ep = !m_ep;
        end
      end else if (m_ov && bus.out_ready) begin
        m_ov = 0;
      end
    end
    @(posedge clk);
    #1;
    check_outs(tag);
    @(negedge clk);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: pick = 32'hFFFF_FFFF;
      1: pick = 32'h8000_0000;
      2: pick = 32'h7FFF_FFFF;
      default: pick = 32'($urandom_range(0, 3));
    endcase
  endfunction

  initial begin
    model_reset();
    bus.out_ready = 1'b1;
    bus.flush     = 1'b0;
    put(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #12;
    check_outs("reset");
    chk("reset.in_ready", bus.in_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;

    // add pass-through
    put(1, 0, 32'h100, 5, 7, 0, 0, 0, 4'b0000, 0, 0, 3, 1);
    cycle("add");
    // taken beq, then a stale follower that must be consumed and dropped
    put(1, 0, 32'h200, 9, 9, 32'h40, 0, 0, 4'b1000, 1, 0, 4, 1);
    cycle("beq");
    chk("beq.epoch_flip_stale", bus.in_ready, 1'b1);
    put(1, 0, 32'h204, 1, 2, 0, 0, 0, 4'b0000, 0, 0, 5, 1);
    cycle("stale");
    // not-taken bltu, then jalr
    put(1, 1, 32'h280, 32'hFFFF_FFFF, 1, 0, 0, 0, 4'b1000, 5, 0, 0, 0);
    cycle("bltu");
    put(1, 1, 32'h300, 32'h1001, 0, 4, 0, 1, 4'b0000, 7, 1, 1, 1);
    cycle("jalr");
    // back-pressure for 3 cycles, then release
    bus.out_ready = 1'b0;
    put(1, 0, 32'h400, 20, 22, 0, 0, 0, 4'b0000, 0, 0, 7, 1);
    for (int i = 0; i < 3; i++) cycle("bp");
    bus.out_ready = 1'b1;
    cycle("bp_release");
    // flush with a taken beq on the input
    bus.flush = 1'b1;
    put(1, 0, 32'h500, 3, 3, 32'h80, 0, 0, 4'b1000, 1, 0, 0, 0);
    cycle("flush");
    bus.flush = 1'b0;
    // pc wrap on jal
    put(1, 0, 32'hFFFF_FFFC, 0, 0, 8, 1, 1, 4'b0000, 7, 0, 2, 1);
    cycle("wrap");
    // misaligned jal, then reset during its redirect cycle
    put(1, 1, 32'h10, 0, 0, 6, 1, 1, 4'b0000, 7, 0, 1, 1);
    cycle("jal_mis");
    put(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outs("async_rst");
    @(negedge clk);
    rst_n = 1'b1;

    // random traffic
    for (int n = 0; n < 400; n++) begin
      logic [2:0]  br;
      logic        as, bs, jr;
      logic [3:0]  ctl;
      br  = 3'($urandom_range(0, 7));
      jr  = 1'($urandom_range(0, 1));
      as  = 1'($urandom_range(0, 1));
      bs  = 1'($urandom_range(0, 1));
      ctl = ($urandom_range(0, 2) == 0) ? 4'b1000 : (($urandom_range(0, 3) == 0) ? 4'b0111 : 4'b0000);
      if (br >= 1 && br <= 6) begin as = 0; bs = 0; end
      if (br == 7 && jr) begin as = 0; bs = 1; ctl = 4'b0000; end
      bus.out_ready = ($urandom_range(0, 9) < 7);
      bus.flush     = ($urandom_range(0, 19) == 0);
      put(1'($urandom_range(0, 9) < 8), ($urandom_range(0, 4) == 0) ? !m_ep : m_ep,
          {$urandom_range(0, 32'h3FFF), 2'b00}, pick(), pick(),
          32'($urandom_range(0, 63) * 2), as, bs, ctl, br, jr,
          5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
      cycle("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
